// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel button debouncer: FSM encoding,
// counter-width helper and default cycle counts for a 50 MHz clock.
package debounce_pkg;

    typedef enum logic [1:0] {
        SOLTO       = 2'd0,
        PRESSIONADO = 2'd1,
        LONGO       = 2'd2
    } estado_t;

    localparam int DEBOUNCE_CICLOS_50MHZ = 500000;
    localparam int LONGO_CICLOS_50MHZ    = 50000000;
    localparam int REPEAT_CICLOS_50MHZ   = 10000000;

    // Smallest width able to hold values 0..n-1, never less than one bit.
    function automatic int largura_cont(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_canal.sv
// One debounce channel: 2-FF synchroniser, debounce counter, press/release/long FSM.
// Optional DEBOUNCE_AUTO_REPEAT_EN re-pulses longo every REPEAT_CICLOS while held.
module debounce_canal
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_50MHZ,
    parameter int LONGO_CICLOS    = LONGO_CICLOS_50MHZ,
    parameter int REPEAT_CICLOS   = REPEAT_CICLOS_50MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic botao_i,
    output logic estavel_o,
    output logic pressionado_o,
    output logic solto_o,
    output logic longo_o
);

    localparam int DEB_W  = largura_cont(DEBOUNCE_CICLOS);
    localparam int HOLD_N = (LONGO_CICLOS > REPEAT_CICLOS) ? LONGO_CICLOS : REPEAT_CICLOS;
    localparam int HOLD_W = largura_cont(HOLD_N);

    localparam logic [DEB_W-1:0]  DEB_FIM   = DEB_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [HOLD_W-1:0] LONGO_FIM = HOLD_W'(LONGO_CICLOS - 1);
`ifdef DEBOUNCE_AUTO_REPEAT_EN
    localparam logic [HOLD_W-1:0] REPEAT_FIM = HOLD_W'(REPEAT_CICLOS - 1);
`else
    localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
`endif

    logic [1:0]        sync_q;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic              estavel_q, estavel_d;
    logic [HOLD_W-1:0] hold_q;
    estado_t           estado_q;
    logic              pressionado_q, solto_q, longo_q;
    logic              diverge, aceita, sobe, desce;

    assign diverge = sync_q[1] != estavel_q;
    assign aceita  = diverge && (deb_q == DEB_FIM);
    assign sobe    = aceita && sync_q[1];
    assign desce   = aceita && !sync_q[1];

    // Any agreeing cycle restarts the window, so short glitches never accumulate.
    always_comb begin
        deb_d     = '0;
        estavel_d = estavel_q;
        if (diverge) begin
            if (deb_q == DEB_FIM) estavel_d = ~estavel_q;
            else                  deb_d     = deb_q + DEB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            deb_q     <= '0;
            estavel_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], botao_i};
            deb_q     <= deb_d;
            estavel_q <= estavel_d;
        end
    end

    // FSM acts on the acceptance event itself so pulses land on the estavel edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q      <= SOLTO;
            hold_q        <= '0;
            pressionado_q <= 1'b0;
            solto_q       <= 1'b0;
            longo_q       <= 1'b0;
        end else begin
            pressionado_q <= 1'b0;
            solto_q       <= 1'b0;
            longo_q       <= 1'b0;
            case (estado_q)
                SOLTO: begin
                    hold_q <= '0;
                    if (sobe) begin
                        estado_q      <= PRESSIONADO;
                        pressionado_q <= 1'b1;
                    end
                end
                PRESSIONADO: begin
                    if (desce) begin
                        estado_q <= SOLTO;
                        solto_q  <= 1'b1;
                        hold_q   <= '0;
                    end else if (hold_q == LONGO_FIM) begin
                        estado_q <= LONGO;
                        longo_q  <= 1'b1;
                        hold_q   <= '0;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                LONGO: begin
                    if (desce) begin
                        estado_q <= SOLTO;
                        solto_q  <= 1'b1;
                        hold_q   <= '0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                    end else if (hold_q == REPEAT_FIM) begin
                        longo_q <= 1'b1;
                        hold_q  <= '0;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
`else
                    end else if (hold_q != HOLD_MAX) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
`endif
                end
                default: begin
                    estado_q <= SOLTO;
                    hold_q   <= '0;
                end
            endcase
        end
    end

    assign estavel_o     = estavel_q;
    assign pressionado_o = pressionado_q;
    assign solto_o       = solto_q;
    assign longo_o       = longo_q;

endmodule

// File: rtl/debounce_multicanal.sv
// N independent debounce channels; honours DEBOUNCE_AUTO_REPEAT_EN through
// debounce_canal. No arbitration: channels run fully in parallel.
module debounce_multicanal
    import debounce_pkg::*;
#(
    parameter int N_CANAIS        = 4,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_50MHZ,
    parameter int LONGO_CICLOS    = LONGO_CICLOS_50MHZ,
    parameter int REPEAT_CICLOS   = REPEAT_CICLOS_50MHZ
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CANAIS-1:0] botao_in,
    output logic [N_CANAIS-1:0] estavel,
    output logic [N_CANAIS-1:0] pressionado,
    output logic [N_CANAIS-1:0] solto,
    output logic [N_CANAIS-1:0] longo
);

    for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
        debounce_canal #(
            .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
            .LONGO_CICLOS    (LONGO_CICLOS),
            .REPEAT_CICLOS   (REPEAT_CICLOS)
        ) u_canal (
            .clk           (clk),
            .rst_n         (rst_n),
            .botao_i       (botao_in[i]),
            .estavel_o     (estavel[i]),
            .pressionado_o (pressionado[i]),
            .solto_o       (solto[i]),
            .longo_o       (longo[i])
        );
    end

endmodule

// File: tb/tb_debounce_multicanal.sv
// Directed bench for debounce_multicanal with D=4, L=20, R=8, 4 channels.
module tb_debounce_multicanal;

    localparam int N = 4;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
    localparam int LONGO_ESP = 3;
`else
    localparam int LONGO_ESP = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] botao_in = '0;
    logic [N-1:0] estavel, pressionado, solto, longo;

    int n_vec = 0;
    int n_err = 0;
    int n_press[N] = '{default: 0};
    int n_solto[N] = '{default: 0};
    int n_longo[N] = '{default: 0};

    always #5 clk = ~clk;

    debounce_multicanal #(
        .N_CANAIS        (N),
        .DEBOUNCE_CICLOS (4),
        .LONGO_CICLOS    (20),
        .REPEAT_CICLOS   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .botao_in    (botao_in),
        .estavel     (estavel),
        .pressionado (pressionado),
        .solto       (solto),
        .longo       (longo)
    );

    // Pulse tallies, sampled mid-cycle.
    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            n_press[c] += int'(pressionado[c]);
            n_solto[c] += int'(solto[c]);
            n_longo[c] += int'(longo[c]);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, b2, b3;

        // Reset state
        rst_n    = 1'b0;
        botao_in = '0;
        tick(3);
        chk("reset_estavel", 32'(estavel), 32'h0);
        chk("reset_press", 32'(pressionado), 32'h0);
        chk("reset_solto", 32'(solto), 32'h0);
        chk("reset_longo", 32'(longo), 32'h0);
        rst_n = 1'b1;
        tick(4);

        // Clean press on ch0: accepted at cycle 6
        b1 = n_press[1] + n_press[2] + n_press[3];
        b0 = n_press[0];
        botao_in[0] = 1'b1;
        tick(5);
        chk("t1_estavel_c5", 32'(estavel), 32'h0);
        chk("t1_press_c5", 32'(pressionado), 32'h0);
        tick(1);
        chk("t1_estavel_c6", 32'(estavel), 32'h1);
        chk("t1_press_c6", 32'(pressionado), 32'h1);
        tick(1);
        chk("t1_press_c7", 32'(pressionado), 32'h0);
        botao_in[0] = 1'b0;
        tick(6);
        chk("t1_solto", 32'(solto), 32'h1);
        chk("t1_estavel_off", 32'(estavel), 32'h0);
        tick(2);
        chk("t1_press_count_ch0", n_press[0] - b0, 1);
        chk("t1_press_others", n_press[1] + n_press[2] + n_press[3] - b1, 0);

        // Glitch rejection on ch1: 3 cycles rejected, 4 cycles accepted
        b1 = n_press[1];
        botao_in[1] = 1'b1;
        tick(3);
        botao_in[1] = 1'b0;
        tick(10);
        chk("t2_glitch_estavel", 32'(estavel), 32'h0);
        chk("t2_glitch_press", n_press[1] - b1, 0);
        botao_in[1] = 1'b1;
        tick(4);
        botao_in[1] = 1'b0;
        tick(2);
        chk("t2_4cyc_estavel", 32'(estavel), 32'h2);
        chk("t2_4cyc_press", 32'(pressionado), 32'h2);
        tick(4);
        chk("t2_4cyc_solto", 32'(solto), 32'h2);
        tick(4);

        // Bounce train on ch3, then steady high from cycle 20
        b3 = n_press[3];
        for (int i = 0; i < 20; i++) begin
            botao_in[3] = ((i / 2) % 2 == 0);
            tick(1);
        end
        botao_in[3] = 1'b1;
        tick(5);
        chk("t3_estavel_c25", 32'(estavel), 32'h0);
        tick(1);
        chk("t3_press_c26", 32'(pressionado), 32'h8);
        chk("t3_estavel_c26", 32'(estavel), 32'h8);
        tick(2);
        chk("t3_press_count", n_press[3] - b3, 1);
        botao_in[3] = 1'b0;
        tick(8);

        // Long press on ch2: longo 20 cycles after estavel rose
        b2 = n_longo[2];
        b3 = n_solto[2];
        botao_in[2] = 1'b1;
        tick(6);
        chk("t4_press", 32'(pressionado), 32'h4);
        tick(19);
        chk("t4_longo_c25", 32'(longo), 32'h0);
        tick(1);
        chk("t4_longo_c26", 32'(longo), 32'h4);
        tick(1);
        chk("t4_longo_c27", 32'(longo), 32'h0);
        tick(13);
        botao_in[2] = 1'b0;
        tick(6);
        chk("t4_solto", 32'(solto), 32'h4);
        chk("t4_estavel_off", 32'(estavel), 32'h0);
        tick(4);
        chk("t4_longo_count", n_longo[2] - b2, LONGO_ESP);
        chk("t4_solto_count", n_solto[2] - b3, 1);

        // Simultaneous ch0+ch3; ch0 released on its long-press threshold cycle
        b0 = n_longo[0];
        botao_in = 4'b1001;
        tick(6);
        chk("t5_press_both", 32'(pressionado), 32'h9);
        tick(14);
        botao_in[0] = 1'b0;
        tick(6);
        chk("t5_solto_ch0", 32'(solto), 32'h1);
        chk("t5_longo_ch3_only", 32'(longo), 32'h8);
        botao_in[3] = 1'b0;
        tick(10);
        chk("t5_longo_ch0_count", n_longo[0] - b0, 0);
        chk("t5_estavel_idle", 32'(estavel), 32'h0);

        // Async reset while ch2 is held
        botao_in[2] = 1'b1;
        tick(10);
        chk("t6_estavel_held", 32'(estavel), 32'h4);
        b2 = n_solto[0] + n_solto[1] + n_solto[2] + n_solto[3];
        b3 = n_longo[0] + n_longo[1] + n_longo[2] + n_longo[3];
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_estavel", 32'(estavel), 32'h0);
        chk("t6_rst_pulses", 32'(pressionado | solto | longo), 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        chk("t6_estavel_c5", 32'(estavel), 32'h0);
        tick(1);
        chk("t6_press_c6", 32'(pressionado), 32'h4);
        chk("t6_estavel_c6", 32'(estavel), 32'h4);
        chk("t6_no_solto", n_solto[0] + n_solto[1] + n_solto[2] + n_solto[3] - b2, 0);
        chk("t6_no_longo", n_longo[0] + n_longo[1] + n_longo[2] + n_longo[3] - b3, 0);
        botao_in = '0;
        tick(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
